// File: rtl/pad_data_generator.sv
// pad_data_generator: emits {BCID, hits} pad frames with a one-cycle valid strobe at BC cadence
// for exercising the receive-side pad data checker.
module pad_data_generator #(
  parameter int BC_DIV   = 4,
  parameter int BCID_MAX = 3563,
  parameter int NCH      = 104
) (
  input  logic              clk160,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [NCH-1:0]    fixed_pattern,
  input  logic [7:0]        hit_period,
  input  logic [15:0]       frame_count,
  input  logic              bcr,
  output logic [NCH+11:0]   pad_data_out,
  output logic              pad_data_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frames_sent
);
  localparam int PW = BC_DIV > 1 ? $clog2(BC_DIV) : 1;
  localparam int WW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE = NCH'(1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [PW-1:0]     r_phase;
  logic [11:0]       r_bcid, w_bcid_nx;
  logic [7:0]        r_gap;
  logic [WW-1:0]     r_walk;
  logic [15:0]       r_sent;
  logic [NCH+11:0]   r_out;
  logic              r_valid, r_busy, r_done;
  logic [NCH-1:0]    w_hits;
  logic              w_tick, w_emit, w_last, w_start;
  always_comb begin
    w_tick    = r_phase == PW'(BC_DIV - 1);
    w_bcid_nx = bcr ? 12'd0 : w_tick ? (r_bcid == 12'(BCID_MAX) ? 12'd0 : r_bcid + 12'd1) : r_bcid;
    w_start   = r_state == S_IDLE && enable;
    w_emit    = r_state == S_RUN && enable && w_tick && r_gap == 8'd0;
    w_last    = w_emit && frame_count != 16'd0 && {1'b0, r_sent} + 17'd1 == {1'b0, frame_count};
    w_hits    = mode == 2'd0 ? fixed_pattern : mode == 2'd1 ? ONE << r_walk : {NCH{mode == 2'd2}};
    w_next    = r_state == S_IDLE ? (enable ? S_RUN : S_IDLE) :
                !enable ? S_IDLE : w_last ? S_DONE : r_state;
  end
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bcid  <= '0;
      r_gap   <= '0;
      r_walk  <= '0;
      r_sent  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= (bcr || w_tick) ? '0 : r_phase + PW'(1);
      r_bcid  <= w_bcid_nx;
      r_valid <= w_emit;
      r_busy  <= w_next == S_RUN;
      r_done  <= w_next == S_DONE;
      if (w_emit) r_out <= {w_bcid_nx, w_hits};
      // gap counts the idle BCs still owed before the next frame may go out
      if (w_start) begin
        r_sent <= '0;
        r_walk <= '0;
        r_gap  <= '0;
      end else if (w_emit) begin
        r_gap  <= hit_period == 8'd0 ? 8'd0 : hit_period - 8'd1;
        r_sent <= r_sent == 16'hFFFF ? r_sent : r_sent + 16'd1;
        r_walk <= r_walk == WW'(NCH - 1) ? '0 : r_walk + WW'(1);
      end else if (w_tick && r_gap != 8'd0) begin
        r_gap  <= r_gap - 8'd1;
      end
    end
  end
  assign pad_data_out   = r_out;
  assign pad_data_valid = r_valid;
  assign busy           = r_busy;
  assign done           = r_done;
  assign frames_sent    = r_sent;
endmodule

// File: tb/tb_pad_data_generator.sv
// tb_pad_data_generator: directed-vector bench for pad_data_generator.
module tb_pad_data_generator;
  logic          clk160 = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [103:0]  fixed_pattern = 104'd1;
  logic [7:0]    hit_period = 8'd1;
  logic [15:0]   frame_count = 16'd5;
  logic          bcr = 1'b0;
  logic [115:0]  pad_data_out;
  logic          pad_data_valid, busy, done;
  logic [15:0]   frames_sent;
  int            n_chk = 0, n_pass = 0;

  pad_data_generator dut (
    .clk160(clk160), .reset_n(reset_n), .enable(enable), .mode(mode),
    .fixed_pattern(fixed_pattern), .hit_period(hit_period), .frame_count(frame_count),
    .bcr(bcr), .pad_data_out(pad_data_out), .pad_data_valid(pad_data_valid),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk160 = ~clk160;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_strobe(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk160);
      n++;
    end while (!pad_data_valid && n <= lim);
  endtask

  initial begin
    int n, sp_err, br_err, one_err, wraps;
    logic [11:0]  prev;
    logic [103:0] one = 104'd1;
    logic [103:0] pat = 104'h00DE_AD00_0000_BEEF_0000_0012_34;
    logic [15:0]  s0;
    repeat (3) @(negedge clk160);
    chk("rst_out", pad_data_out, 0);
    chk("rst_valid", pad_data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", frames_sent, 0);
    // fixed pattern, five frames
    enable = 1'b1;
    reset_n = 1'b1;
    wait_strobe(20, n);
    chk("t1_first_lat", n, 4);
    chk("t1_bcid0", pad_data_out[115:104], 1);
    chk("t1_hits0", pad_data_out[103:0], 1);
    chk("t1_busy", busy, 1);
    for (int k = 1; k < 5; k++) begin
      wait_strobe(8, n);
      chk("t1_space", n, 4);
      chk("t1_bcid", pad_data_out[115:104], k + 1);
      chk("t1_hits", pad_data_out[103:0], 1);
    end
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_sent", frames_sent, 5);
    wait_strobe(12, n);
    chk("t1_no_sixth", n > 12, 1);
    chk("t1_done_hold", done, 1);
    enable = 1'b0;
    @(negedge clk160);
    chk("t1_done_clr", done, 0);
    chk("t1_sent_hold", frames_sent, 5);
    // walking one, continuous, long enough to cross the BCID wrap
    mode = 2'd1;
    frame_count = 16'd0;
    enable = 1'b1;
    sp_err = 0; br_err = 0; one_err = 0; wraps = 0;
    wait_strobe(20, n);
    chk("t2_start", n <= 20, 1);
    prev = pad_data_out[115:104];
    for (int k = 0; k < 3570; k++) begin
      if (k > 0) begin
        wait_strobe(8, n);
        if (n != 4) sp_err++;
        if (n > 8) break;
        if (pad_data_out[115:104] != ((prev == 12'd3563) ? 12'd0 : prev + 12'd1)) br_err++;
        if (prev == 12'd3563 && pad_data_out[115:104] == 12'd0) wraps++;
        prev = pad_data_out[115:104];
      end
      if (k < 106) chk("t2_walk", pad_data_out[103:0], one << (k % 104));
      if ($countones(pad_data_out[103:0]) != 1) one_err++;
    end
    chk("t2_spacing", sp_err, 0);
    chk("t2_bcid_seq", br_err, 0);
    chk("t2_onehot", one_err, 0);
    chk("t2_wrap", wraps, 1);
    // all-ones, then bcr coincident with and away from a bc_tick
    mode = 2'd2;
    wait_strobe(8, n);
    chk("t3_ones", pad_data_out[103:0], {104{1'b1}});
    repeat (3) @(negedge clk160);
    bcr = 1'b1;
    @(negedge clk160);
    bcr = 1'b0;
    chk("t3_bcr_valid", pad_data_valid, 1);
    chk("t3_bcr_bcid", pad_data_out[115:104], 0);
    wait_strobe(8, n);
    chk("t3_after_space", n, 4);
    chk("t3_after_bcid", pad_data_out[115:104], 1);
    @(negedge clk160);
    bcr = 1'b1;
    @(negedge clk160);
    bcr = 1'b0;
    wait_strobe(8, n);
    chk("t3_phase_rst_space", n, 4);
    chk("t3_phase_rst_bcid", pad_data_out[115:104], 1);
    // hit_period 3, empty hits, changed mid-run
    hit_period = 8'd3;
    mode = 2'd3;
    s0 = frames_sent;
    wait_strobe(8, n);
    chk("t4_space_first", n, 4);
    chk("t4_hits_first", pad_data_out[103:0], 0);
    wait_strobe(20, n);
    chk("t4_space", n, 12);
    chk("t4_hits", pad_data_out[103:0], 0);
    chk("t4_sent", frames_sent, s0 + 16'd2);
    // abort after frame 2 of 10, then restart
    enable = 1'b0;
    @(negedge clk160);
    mode = 2'd0;
    fixed_pattern = pat;
    hit_period = 8'd1;
    frame_count = 16'd10;
    enable = 1'b1;
    wait_strobe(20, n);
    chk("t5_start", n <= 20, 1);
    chk("t5_hits", pad_data_out[103:0], pat);
    wait_strobe(8, n);
    chk("t5_space", n, 4);
    chk("t5_sent2", frames_sent, 2);
    enable = 1'b0;
    @(negedge clk160);
    chk("t5_busy_fall", busy, 0);
    chk("t5_sent_hold", frames_sent, 2);
    wait_strobe(12, n);
    chk("t5_no_strobe", n > 12, 1);
    enable = 1'b1;
    @(negedge clk160);
    chk("t5_rerun_busy", busy, 1);
    chk("t5_rerun_sent", frames_sent, 0);
    wait_strobe(20, n);
    chk("t5_rerun_first", frames_sent, 1);
    // asynchronous reset while a strobe is high
    #1 reset_n = 1'b0;
    #1;
    chk("t6_out", pad_data_out, 0);
    chk("t6_valid", pad_data_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_sent", frames_sent, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
